// File: rtl/cash_accumulator_if.sv
// Coin/ticket/refund bundle between the ticket controller and the cash accumulator.
// slave : accumulator side (controls and coins in, credit/pulses out)
// master: controller side (drives controls and coins, observes credit/pulses)
interface cash_if;
  logic       rst_cash_accum;
  logic       en_cash_accum;
  logic       block_cash;
  logic       rst_refund;
  logic       en_refund;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic [7:0] credit;
  logic       dispatch_ticket;
  logic       coin_reject;
  logic       refund_pulse;
  logic [1:0] refund_coin;
  logic       refund_done;

  modport slave (
    input  rst_cash_accum, en_cash_accum, block_cash, rst_refund, en_refund,
    input  coin_valid, coin_type,
    output credit, dispatch_ticket, coin_reject, refund_pulse, refund_coin, refund_done
  );

  modport master (
    output rst_cash_accum, en_cash_accum, block_cash, rst_refund, en_refund,
    output coin_valid, coin_type,
    input  credit, dispatch_ticket, coin_reject, refund_pulse, refund_coin, refund_done
  );
endinterface

// File: rtl/cash_accumulator.sv
// Cash accumulator: collects coins into credit, dispatches one ticket when the
// price is reached, and refunds remaining credit as greedy-denomination coins.
// Ports: clk, rst (async, active-high), bus (cash_if.slave) carrying controls,
// coin input, credit, ticket/reject/refund pulses and refund_done level.
module cash_accumulator #(
  parameter logic [7:0]  PRICE = 8'd15,
  parameter int unsigned GAP   = 4
) (
  input logic  clk,
  input logic  rst,
  cash_if.slave bus
);

  localparam int unsigned CNT_W = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP - 2);

  typedef enum logic [1:0] {R_IDLE, R_EJECT, R_GAP, R_DONE} r_state_t;

  r_state_t         state, state_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             sold, sold_nxt;
  logic [7:0]       credit_nxt;
  logic             disp_nxt, rej_nxt, pulse_nxt, done_nxt;
  logic [1:0]       coin_nxt;

  logic             take, accept, disp;
  logic [8:0]       sum9, base9;
  logic [1:0]       ej_code;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   return 8'd1;
      2'b01:   return 8'd2;
      2'b10:   return 8'd5;
      default: return 8'd10;
    endcase
  endfunction

  // Largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] greedy_code(input logic [7:0] c);
    if (c >= 8'd10)     return 2'b11;
    else if (c >= 8'd5) return 2'b10;
    else if (c >= 8'd2) return 2'b01;
    else                return 2'b00;
  endfunction

  // State register: engine state, gap counter, credit and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= R_IDLE;
      gap_cnt             <= '0;
      sold                <= 1'b0;
      bus.credit          <= '0;
      bus.dispatch_ticket <= 1'b0;
      bus.coin_reject     <= 1'b0;
      bus.refund_pulse    <= 1'b0;
      bus.refund_coin     <= 2'b00;
      bus.refund_done     <= 1'b0;
    end else begin
      state               <= state_nxt;
      gap_cnt             <= gap_cnt_nxt;
      sold                <= sold_nxt;
      bus.credit          <= credit_nxt;
      bus.dispatch_ticket <= disp_nxt;
      bus.coin_reject     <= rej_nxt;
      bus.refund_pulse    <= pulse_nxt;
      bus.refund_coin     <= coin_nxt;
      bus.refund_done     <= done_nxt;
    end
  end

  // Refund engine next state; either clear returns it to idle.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    if (bus.rst_cash_accum || bus.rst_refund) begin
      state_nxt   = R_IDLE;
      gap_cnt_nxt = '0;
    end else begin
      case (state)
        R_IDLE: begin
          if (bus.en_refund) state_nxt = (bus.credit != 8'd0) ? R_EJECT : R_DONE;
        end
        R_EJECT: begin
          state_nxt   = R_GAP;
          gap_cnt_nxt = '0;
        end
        R_GAP: begin
          if (gap_cnt == CNT_LAST) begin
            gap_cnt_nxt = '0;
            // A dropped en_refund only takes effect once the gap has elapsed.
            if (!bus.en_refund)           state_nxt = R_IDLE;
            else if (bus.credit != 8'd0)  state_nxt = R_EJECT;
            else                          state_nxt = R_DONE;
          end else begin
            gap_cnt_nxt = gap_cnt + 1'b1;
          end
        end
        R_DONE:  state_nxt = R_DONE;
        default: state_nxt = R_IDLE;
      endcase
    end
  end

  // Next values of credit, sold flag and output pulses.
  always_comb begin
    credit_nxt = bus.credit;
    sold_nxt   = sold;
    disp_nxt   = 1'b0;
    rej_nxt    = 1'b0;
    pulse_nxt  = 1'b0;
    coin_nxt   = 2'b00;
    done_nxt   = (state_nxt == R_DONE);

    // The engine owns credit on an eject edge; coins and dispatch stand aside.
    take    = (state == R_EJECT) && !bus.rst_refund;
    ej_code = greedy_code(bus.credit);
    sum9    = {1'b0, bus.credit} + 9'(coin_value(bus.coin_type));
    accept  = bus.coin_valid && bus.en_cash_accum && !bus.block_cash &&
              !bus.en_refund && !take && !sum9[8];
    disp    = bus.en_cash_accum && !bus.block_cash && !sold && !bus.en_refund &&
              !take && (bus.credit >= PRICE);
    base9   = accept ? sum9 : {1'b0, bus.credit};

    if (bus.rst_cash_accum) begin
      credit_nxt = 8'd0;
      sold_nxt   = 1'b0;
    end else begin
      rej_nxt = bus.coin_valid && !accept;
      if (take) begin
        pulse_nxt  = 1'b1;
        coin_nxt   = ej_code;
        credit_nxt = bus.credit - coin_value(ej_code);
      end else begin
        // Dispatch tests pre-edge credit; a same-edge coin still lands.
        if (disp) base9 = base9 - {1'b0, PRICE};
        credit_nxt = base9[7:0];
        disp_nxt   = disp;
        if (disp) sold_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cash_accumulator.sv
module tb_cash_accumulator;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  cash_if cif ();

  cash_accumulator #(.PRICE(8'd15), .GAP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst_cash_accum, en_cash_accum, block_cash, rst_refund, en_refund, coin_valid}
  // exp = {credit[7:0], dispatch_ticket, coin_reject, refund_pulse, refund_coin[1:0], refund_done}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  ct;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t v(input logic [5:0] ctl, input logic [1:0] ct, input logic [13:0] exp);
    vec_t r;
    r.ctl = ctl;
    r.ct  = ct;
    r.exp = exp;
    return r;
  endfunction

  task automatic set_in(input logic [5:0] ctl, input logic [1:0] ct);
    cif.rst_cash_accum = ctl[5];
    cif.en_cash_accum  = ctl[4];
    cif.block_cash     = ctl[3];
    cif.rst_refund     = ctl[2];
    cif.en_refund      = ctl[1];
    cif.coin_valid     = ctl[0];
    cif.coin_type      = ct;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {cif.credit, cif.dispatch_ticket, cif.coin_reject, cif.refund_pulse,
           cif.refund_coin, cif.refund_done};
    total++;
    if (act !== exp)
      $display("FAIL %s: got credit=%0d disp/rej/pulse/coin/done=%b, expected credit=%0d disp/rej/pulse/coin/done=%b",
               name, act[13:6], act[5:0], exp[13:6], exp[5:0]);
    else
      passed++;
  endtask

  // Apply one control/coin pattern for a cycle and check outputs after the edge.
  task automatic step(input string name, input logic [5:0] ctl, input logic [1:0] ct,
                      input logic [13:0] exp);
    set_in(ctl, ct);
    cyc();
    check(name, exp);
  endtask

  initial begin
    logic [13:0] e;
    logic [7:0]  c;
    total  = 0;
    passed = 0;

    // Baseline walk: sale, single-sale lockout, clear, reject paths, 5-unit refund.
    vecs[0]  = v(6'b010001, 2'b11, {8'd10, 6'b000000});
    vecs[1]  = v(6'b010001, 2'b10, {8'd15, 6'b000000});
    vecs[2]  = v(6'b010000, 2'b00, {8'd0,  6'b100000});
    vecs[3]  = v(6'b010001, 2'b11, {8'd10, 6'b000000});
    vecs[4]  = v(6'b010000, 2'b00, {8'd10, 6'b000000});
    vecs[5]  = v(6'b010001, 2'b10, {8'd15, 6'b000000});
    vecs[6]  = v(6'b010000, 2'b00, {8'd15, 6'b000000});
    vecs[7]  = v(6'b110000, 2'b00, {8'd0,  6'b000000});
    vecs[8]  = v(6'b010001, 2'b11, {8'd10, 6'b000000});
    vecs[9]  = v(6'b010001, 2'b11, {8'd20, 6'b000000});
    vecs[10] = v(6'b010000, 2'b00, {8'd5,  6'b100000});
    vecs[11] = v(6'b011001, 2'b00, {8'd5,  6'b010000});
    vecs[12] = v(6'b000001, 2'b00, {8'd5,  6'b010000});
    vecs[13] = v(6'b010000, 2'b00, {8'd5,  6'b000000});
    vecs[14] = v(6'b010010, 2'b00, {8'd5,  6'b000000});
    vecs[15] = v(6'b010010, 2'b00, {8'd0,  6'b001100});
    vecs[16] = v(6'b010010, 2'b00, {8'd0,  6'b000000});
    vecs[17] = v(6'b010010, 2'b00, {8'd0,  6'b000000});
    vecs[18] = v(6'b010010, 2'b00, {8'd0,  6'b000001});
    vecs[19] = v(6'b010010, 2'b00, {8'd0,  6'b000001});
    vecs[20] = v(6'b010000, 2'b00, {8'd0,  6'b000001});
    vecs[21] = v(6'b010100, 2'b00, {8'd0,  6'b000000});
    vecs[22] = v(6'b010000, 2'b00, {8'd0,  6'b000000});
    vecs[23] = v(6'b010011, 2'b11, {8'd0,  6'b010001});
    vecs[24] = v(6'b010100, 2'b00, {8'd0,  6'b000000});

    set_in(6'b000000, 2'b00);
    rst = 1'b1;
    #3;
    check("reset_state", 14'd0);
    #9 rst = 1'b0;

    for (int i = 0; i < 25; i++)
      step($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].ct, vecs[i].exp);

    // Overflow boundary: fill to 250 after a sale, then reject / accept at the 255 edge.
    step("ovf_clear", 6'b110000, 2'b00, {8'd0, 6'b000000});
    step("ovf_c10",   6'b010001, 2'b11, {8'd10, 6'b000000});
    step("ovf_c5",    6'b010001, 2'b10, {8'd15, 6'b000000});
    step("ovf_sale",  6'b010000, 2'b00, {8'd0, 6'b100000});
    for (int k = 0; k < 25; k++) begin
      c = 8'(10 * (k + 1));
      step($sformatf("ovf_fill%0d", k), 6'b010001, 2'b11, {c, 6'b000000});
    end
    step("ovf_rej10",  6'b010001, 2'b11, {8'd250, 6'b010000});
    step("ovf_acc5",   6'b010001, 2'b10, {8'd255, 6'b000000});
    step("ovf_rej1",   6'b010001, 2'b00, {8'd255, 6'b010000});

    // Refund of 8: coins 5, 2, 1 spaced 4 cycles apart, done after the last gap.
    step("r8_clear", 6'b100000, 2'b00, {8'd0, 6'b000000});
    step("r8_c5",    6'b010001, 2'b10, {8'd5, 6'b000000});
    step("r8_c2",    6'b010001, 2'b01, {8'd7, 6'b000000});
    step("r8_c1",    6'b010001, 2'b00, {8'd8, 6'b000000});
    for (int i = 0; i < 14; i++) begin
      if (i < 1)      c = 8'd8;
      else if (i < 5) c = 8'd3;
      else if (i < 9) c = 8'd1;
      else            c = 8'd0;
      e = {c, 6'b000000};
      if (i == 1) e[3:1] = 3'b110;
      if (i == 5) e[3:1] = 3'b101;
      if (i == 9) e[3:1] = 3'b100;
      if (i >= 12) e[0] = 1'b1;
      step($sformatf("r8_cyc%0d", i), 6'b000010, 2'b00, e);
    end
    step("r8_rstref", 6'b000100, 2'b00, {8'd0, 6'b000000});

    // Controller clear in the middle of a refund of 13.
    step("r13_c10",   6'b010001, 2'b11, {8'd10, 6'b000000});
    step("r13_c2",    6'b010001, 2'b01, {8'd12, 6'b000000});
    step("r13_c1",    6'b010001, 2'b00, {8'd13, 6'b000000});
    step("r13_start", 6'b000010, 2'b00, {8'd13, 6'b000000});
    step("r13_eject", 6'b000010, 2'b00, {8'd3, 6'b001110});
    step("r13_clear", 6'b100000, 2'b00, {8'd0, 6'b000000});
    for (int i = 0; i < 8; i++)
      step($sformatf("r13_quiet%0d", i), 6'b000000, 2'b00, {8'd0, 6'b000000});

    // Asynchronous reset while the ticket pulse is high.
    step("ar_c10",  6'b010001, 2'b11, {8'd10, 6'b000000});
    step("ar_c5",   6'b010001, 2'b10, {8'd15, 6'b000000});
    step("ar_sale", 6'b010000, 2'b00, {8'd0, 6'b100000});
    #2 rst = 1'b1;
    #1;
    check("ar_immediate", 14'd0);
    @(negedge clk);
    rst = 1'b0;
    step("ar_after", 6'b000000, 2'b00, {8'd0, 6'b000000});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cash_accumulator.md
CASH_ACCUMULATOR -- requirements
Module: cash_accumulator

Interface
REQ-001 Parameter PRICE, default 8'd15, ticket price in currency units.
REQ-002 Parameter GAP, default 4, clock cycles between successive refund coins (>=2).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rst_cash_accum  input  1  synchronous clear of credit and sold flag (from controller).
REQ-006 en_cash_accum  input  1  coin acceptance and dispatch enabled.
REQ-007 block_cash  input  1  reject all coins.
REQ-008 rst_refund  input  1  synchronous clear of refund engine.
REQ-009 en_refund  input  1  dispense remaining credit as coins.
REQ-010 coin_valid  input  1  one-cycle pulse: coin inserted.
REQ-011 coin_type  input  2  00=1, 01=2, 10=5, 11=10 units; valid with coin_valid.
REQ-012 credit  output  8  current accumulated credit.
REQ-013 dispatch_ticket  output  1  one-cycle pulse: price reached, ticket sold.
REQ-014 coin_reject  output  1  one-cycle pulse: inserted coin returned unaccepted.
REQ-015 refund_pulse  output  1  one-cycle pulse: eject one coin of refund_coin.
REQ-016 refund_coin  output  2  denomination of ejected coin, same encoding as coin_type.
REQ-017 refund_done  output  1  level: refund engine finished, credit is 0.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 Coin accepted iff coin_valid & en_cash_accum & ~block_cash & ~en_refund & (credit + value <= 255); credit SHALL be updated on the same edge.
REQ-020 Coin_valid not accepted SHALL produce coin_reject=1 on the following cycle; credit unchanged (no wrap, no saturation).
REQ-021 Sold flag SHALL be clear after rst/rst_cash_accum; dispatch allowed only when clear.
REQ-022 When en_cash_accum & ~block_cash & ~sold & credit >= PRICE: dispatch_ticket=1 for exactly one cycle, credit <= credit - PRICE, sold set, same edge.
REQ-023 Coin accept and dispatch on the same edge: credit <= credit + value - PRICE (dispatch evaluated on pre-edge credit).
REQ-024 Refund engine states: R_IDLE, R_EJECT, R_GAP, R_DONE.
REQ-025 R_IDLE -> R_EJECT when en_refund=1 and credit>0; -> R_DONE when en_refund=1 and credit=0.
REQ-026 R_EJECT: refund_pulse=1 for one cycle with largest denomination <= credit (greedy 10,5,2,1); credit decremented by that value on the same edge; -> R_GAP.
REQ-027 R_GAP: count GAP-1 cycles, then -> R_EJECT if credit>0, else R_DONE.
REQ-028 R_DONE: refund_done=1; hold until rst_refund or rst_cash_accum.
REQ-029 en_refund deasserted mid-refund: engine completes current gap, then returns to R_IDLE without further coins.
REQ-030 Priority: rst > rst_cash_accum > rst_refund > refund engine > dispatch > coin accept.
REQ-031 rst_cash_accum: credit=0, sold=0, refund engine -> R_IDLE, no pulses that cycle.
REQ-032 rst_refund: refund engine -> R_IDLE, credit preserved.

Reset
REQ-033 On rst: credit=0, dispatch_ticket=0, coin_reject=0, refund_pulse=0, refund_coin=00, refund_done=0, sold=0, engine R_IDLE, gap counter 0; effective immediately, asynchronous.

Verification
REQ-034 en_cash_accum=1, coins 10 then 5 -> credit 10, 15; next cycle dispatch_ticket pulse, credit 0; further coin 10 -> credit 10, no second dispatch.
REQ-035 Coins 10,10 -> dispatch, credit 5; en_refund=1 -> one refund_pulse with refund_coin=10, credit 0, then refund_done=1.
REQ-036 Credit 8, en_refund=1 -> refund_pulse coins 5, 2, 1 spaced exactly GAP cycles; refund_done after last gap.
REQ-037 Credit 250, coin 10 -> coin_reject pulse next cycle, credit stays 250; block_cash=1 with coin 1 -> coin_reject, credit unchanged.
REQ-038 rst_cash_accum asserted mid-refund (credit 13) -> credit 0, no further refund_pulse, engine R_IDLE; async rst mid-dispatch -> all outputs 0 immediately.
